// File: rtl/nmos_cmp_sequencer_pkg.sv
// Shared FSM encodings and parameter legality helper for the compare-latch sequencer.
package nmos_cmp_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WAIT_C1 = 3'd2,
    ST_XFER    = 3'd3,
    ST_SETTLE  = 3'd4
  } seq_state_e;

  // Two non-overlapping strobes need an even period with room between them.
  function automatic bit period_ok(input int period);
    return (period >= 4) && ((period % 2) == 0);
  endfunction

endpackage

// File: rtl/nmos_phase_ctr.sv
// Free-running phase counter: emits registered phi1/phi2 strobes and the
// combinational pre-strobe flags the sequencer uses to line up LD and C1.
module nmos_phase_ctr
  import nmos_cmp_sequencer_pkg::*;
#(
  parameter int PERIOD = 8
) (
  input  logic main_clk,
  input  logic main_rst,
  output logic phi1_o,
  output logic phi2_o,
  output logic pre_phi1_o,
  output logic pre_phi2_o
);

  if (!period_ok(PERIOD)) begin : g_bad_period
    $error("nmos_phase_ctr: PERIOD must be even and >= 4");
  end

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] HALF = CW'(PERIOD / 2 - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  assign pre_phi1_o = (cnt_q == LAST);
  assign pre_phi2_o = (cnt_q == HALF);

  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      cnt_q  <= '0;
      phi1_o <= 1'b0;
      phi2_o <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      phi1_o <= pre_phi1_o;
      phi2_o <= pre_phi2_o;
    end
  end

endmodule

// File: rtl/nmos_cmp_sequencer.sv
// Control stage for a chain of compare-latch cells: loads DB/VV, fires LD on
// phi2 and C1 on the following phi1, then samples the chain's EQO tail.
module nmos_cmp_sequencer
  import nmos_cmp_sequencer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 8
) (
  input  logic             main_clk,
  input  logic             main_rst,
  input  logic             req_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] pat_i,
  output logic             ack_o,
  output logic             phi1_o,
  output logic             phi2_o,
  output logic [WIDTH-1:0] db_o,
  output logic [WIDTH-1:0] vv_o,
  output logic             ld_o,
  output logic             c1_o,
  input  logic             eq_i,
  output logic             done_o,
  output logic             match_o
);

  logic pre_phi1;
  logic pre_phi2;

  nmos_phase_ctr #(
    .PERIOD(PERIOD)
  ) u_phase (
    .main_clk  (main_clk),
    .main_rst  (main_rst),
    .phi1_o    (phi1_o),
    .phi2_o    (phi2_o),
    .pre_phi1_o(pre_phi1),
    .pre_phi2_o(pre_phi2)
  );

  seq_state_e       state_q;
  logic             ack_q;
  logic             ld_q;
  logic             c1_q;
  logic             done_q;
  logic             match_q;
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] vv_q;

  // Pre-strobe flags are used so LD/C1 land in the same cycle as phi2/phi1.
  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      ld_q    <= 1'b0;
      c1_q    <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      db_q    <= '0;
      vv_q    <= '0;
    end else begin
      ack_q  <= 1'b0;
      ld_q   <= 1'b0;
      c1_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            db_q    <= data_i;
            vv_q    <= pat_i;
            ack_q   <= 1'b1;
            state_q <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (pre_phi2) begin
            ld_q    <= 1'b1;
            state_q <= ST_WAIT_C1;
          end
        end
        ST_WAIT_C1: begin
          if (pre_phi1) begin
            c1_q    <= 1'b1;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: state_q <= ST_SETTLE;
        ST_SETTLE: begin
          // Cells transferred at the end of the C1 cycle; EQO is settled now.
          match_q <= eq_i;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack_o   = ack_q;
  assign ld_o    = ld_q;
  assign c1_o    = c1_q;
  assign done_o  = done_q;
  assign match_o = match_q;
  assign db_o    = db_q;
  assign vv_o    = vv_q;

endmodule
